// File: rtl/lpm_match_engine.sv
// lpm_match_engine: longest-prefix-match lookup over an external, synchronously read route table.
//
// Each accepted request scans NUM_ENTRIES table entries in ascending index order. Among the enabled
// entries whose prefix matches the request address under the entry's mask, the engine returns the
// one with the numerically largest mask. When several entries tie on that mask, the lowest index
// wins. A mask of 0 acts as a default route.
//
// Ports:
//   AXI_ACLK, AXI_RESET        clock (rising edge) and asynchronous active-high reset
//   req_valid/req_ready/req_ip request handshake and destination address (sampled on acceptance)
//   tbl_rd_en/tbl_rd_addr      table read strobe and entry index, one entry per cycle while scanning
//   tbl_rd_data                {prefix, mask}, valid one cycle after tbl_rd_en
//   tbl_valid                  per-entry enable bitmap, sampled when each entry is evaluated
//   rsp_valid/rsp_ready        response handshake; lpm_hit/index_hit are held until it completes
//   lpm_miss_count             miss counter, present only when LPM_MISS_COUNT_EN is defined
//
// Optional feature macro: LPM_MISS_COUNT_EN.
module lpm_match_engine #(
  parameter int unsigned NUM_ENTRIES        = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESET,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     req_ip,
  output logic                              tbl_rd_en,
  output logic [4:0]                        tbl_rd_addr,
  input  logic [2*C_S_AXI_DATA_WIDTH-1:0]   tbl_rd_data,
  input  logic [31:0]                       tbl_valid,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              lpm_hit,
  output logic [4:0]                        index_hit
`ifdef LPM_MISS_COUNT_EN
  ,
  output logic [31:0]                       lpm_miss_count
`endif
);

  localparam int unsigned W = C_S_AXI_DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   ip_q, ip_d;
  logic [4:0]     addr_q, addr_d;
  logic           pend_q, pend_d;         // tbl_rd_data holds entry pend_idx_q this cycle
  logic [4:0]     pend_idx_q, pend_idx_d;
  logic           hit_q, hit_d;
  logic [4:0]     idx_q, idx_d;
  logic [W-1:0]   best_mask_q, best_mask_d;
  logic           rsp_valid_q, rsp_valid_d;

  logic           accept;
  logic           handshake;
  logic           last_addr;
  logic [W-1:0]   entry_prefix;
  logic [W-1:0]   entry_mask;
  logic           entry_match;

  assign last_addr    = (addr_q == 5'(NUM_ENTRIES - 1));
  assign entry_prefix = tbl_rd_data[2*W-1:W];
  assign entry_mask   = tbl_rd_data[W-1:0];
  assign entry_match  = tbl_valid[pend_idx_q] && (((ip_q ^ entry_prefix) & entry_mask) == '0);

  // Control FSM
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    tbl_rd_en = 1'b0;
    accept    = 1'b0;
    handshake = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = StScan;
        end
      end
      StScan: begin
        tbl_rd_en = 1'b1;
        if (last_addr) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (rsp_valid_q && rsp_ready) begin
          handshake = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next state
  always_comb begin
    ip_d        = ip_q;
    addr_d      = addr_q;
    pend_d      = tbl_rd_en;
    pend_idx_d  = addr_q;
    hit_d       = hit_q;
    idx_d       = idx_q;
    best_mask_d = best_mask_q;

    if (state_q == StScan) begin
      addr_d = last_addr ? 5'd0 : addr_q + 5'd1;
    end

    // Strict '>' keeps the earlier (lower) index on equal masks; the first match always lands so a
    // zero-mask default route is kept until something more specific appears.
    if (pend_q && entry_match && (!hit_q || (entry_mask > best_mask_q))) begin
      hit_d       = 1'b1;
      idx_d       = pend_idx_q;
      best_mask_d = entry_mask;
    end

    if (accept) begin
      ip_d        = req_ip;
      addr_d      = 5'd0;
      hit_d       = 1'b0;
      idx_d       = 5'd0;
      best_mask_d = '0;
    end

    // Raise the response once the final entry's evaluation has been folded in.
    rsp_valid_d = (state_q == StDone) && !pend_q && !handshake;
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      ip_q        <= '0;
      addr_q      <= 5'd0;
      pend_q      <= 1'b0;
      pend_idx_q  <= 5'd0;
      hit_q       <= 1'b0;
      idx_q       <= 5'd0;
      best_mask_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      ip_q        <= ip_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      hit_q       <= hit_d;
      idx_q       <= idx_d;
      best_mask_q <= best_mask_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign tbl_rd_addr = addr_q;
  assign rsp_valid   = rsp_valid_q;
  assign lpm_hit     = hit_q;
  assign index_hit   = idx_q;

`ifdef LPM_MISS_COUNT_EN
  logic [31:0] miss_q;

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      miss_q <= 32'd0;
    end else if (handshake && !hit_q) begin
      miss_q <= miss_q + 32'd1;
    end
  end

  assign lpm_miss_count = miss_q;
`endif

endmodule

// File: tb/tb_lpm_match_engine.sv
// Self-checking bench for lpm_match_engine: directed lookups followed by randomized route tables,
// each checked against a longest-prefix reference model.
module tb_lpm_match_engine;

  localparam int NUM = 32;

  logic        clk;
  logic        AXI_RESET;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_ip;
  logic        tbl_rd_en;
  logic [4:0]  tbl_rd_addr;
  logic [63:0] tbl_rd_data;
  logic [31:0] tbl_valid;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        lpm_hit;
  logic [4:0]  index_hit;
`ifdef LPM_MISS_COUNT_EN
  logic [31:0] lpm_miss_count;
`endif

  logic [31:0] tb_prefix [NUM];
  logic [31:0] tb_mask   [NUM];
  logic [31:0] miss_model;

  int n_total;
  int n_pass;
  int n_fail;

  lpm_match_engine #(
    .NUM_ENTRIES        (NUM),
    .C_S_AXI_DATA_WIDTH (32)
  ) dut (
    .AXI_ACLK    (clk),
    .AXI_RESET   (AXI_RESET),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_ip      (req_ip),
    .tbl_rd_en   (tbl_rd_en),
    .tbl_rd_addr (tbl_rd_addr),
    .tbl_rd_data (tbl_rd_data),
    .tbl_valid   (tbl_valid),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .lpm_hit     (lpm_hit),
    .index_hit   (index_hit)
`ifdef LPM_MISS_COUNT_EN
    ,
    .lpm_miss_count (lpm_miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read table: data for the strobed address appears one cycle later.
  always @(posedge clk) begin
    if (tbl_rd_en) tbl_rd_data <= {tb_prefix[tbl_rd_addr], tb_mask[tbl_rd_addr]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ip4(input int a, input int b, input int c, input int d);
    return {8'(a), 8'(b), 8'(c), 8'(d)};
  endfunction

  function automatic logic [31:0] len_mask(input int len);
    return (len == 0) ? 32'h0 : (32'hFFFF_FFFF << (32 - len));
  endfunction

  task automatic clear_table();
    tbl_valid = 32'h0;
    for (int i = 0; i < NUM; i++) begin
      tb_prefix[i] = 32'h0;
      tb_mask[i]   = 32'h0;
    end
  endtask

  // Reference: collect every enabled matching entry, take the longest mask, then the lowest index
  // carrying that mask.
  task automatic ref_lookup(input logic [31:0] ip, output logic hit, output logic [4:0] idx);
    int q[$];
    logic [31:0] best;
    hit  = 1'b0;
    idx  = 5'd0;
    best = 32'h0;
    for (int i = 0; i < NUM; i++) begin
      if (tbl_valid[i] && ((ip & tb_mask[i]) == (tb_prefix[i] & tb_mask[i]))) q.push_back(i);
    end
    if (q.size() > 0) begin
      hit = 1'b1;
      foreach (q[k]) if (tb_mask[q[k]] > best) best = tb_mask[q[k]];
      for (int k = q.size() - 1; k >= 0; k--) if (tb_mask[q[k]] == best) idx = 5'(q[k]);
    end
  endtask

  task automatic lookup(input string tag, input logic [31:0] ip, input int hold,
                        input logic exp_hit, input logic [4:0] exp_idx);
    int   lat;
    logic ok;
    @(negedge clk);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_ip    = ip;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_ip    = $urandom();  // must not affect the lookup in flight
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(NUM + 2));
    check({tag, ".lpm_hit"}, 32'(lpm_hit), 32'(exp_hit));
    check({tag, ".index_hit"}, 32'(index_hit), 32'(exp_idx));
    ok = 1'b1;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b1 || lpm_hit !== exp_hit || index_hit !== exp_idx || req_ready !== 1'b0)
        ok = 1'b0;
    end
    if (hold > 0) check({tag, ".hold_stable"}, 32'(ok), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    if (!exp_hit) miss_model = miss_model + 32'd1;
    check({tag, ".post_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, ".post_rsp_valid"}, 32'(rsp_valid), 32'd0);
`ifdef LPM_MISS_COUNT_EN
    check({tag, ".miss_count"}, lpm_miss_count, miss_model);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".lpm_hit"}, 32'(lpm_hit), 32'd0);
    check({tag, ".index_hit"}, 32'(index_hit), 32'd0);
    check({tag, ".tbl_rd_en"}, 32'(tbl_rd_en), 32'd0);
    check({tag, ".tbl_rd_addr"}, 32'(tbl_rd_addr), 32'd0);
`ifdef LPM_MISS_COUNT_EN
    check({tag, ".miss_count"}, lpm_miss_count, 32'd0);
`endif
  endtask

  task automatic setup_two_routes();
    clear_table();
    tb_prefix[3] = ip4(10, 0, 0, 0);
    tb_mask[3]   = ip4(255, 0, 0, 0);
    tb_prefix[7] = ip4(10, 1, 0, 0);
    tb_mask[7]   = ip4(255, 255, 0, 0);
    tbl_valid    = 32'h0000_0088;
  endtask

  initial begin
    logic        e_hit;
    logic [4:0]  e_idx;
    logic [31:0] ip;
    logic        ok;
    int          hold;
    int          len;

    n_total    = 0;
    n_pass     = 0;
    n_fail     = 0;
    miss_model = 32'd0;
    clk        = 1'b0;
    AXI_RESET  = 1'b1;
    req_valid  = 1'b0;
    req_ip     = 32'h0;
    rsp_ready  = 1'b0;
    clear_table();

    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    AXI_RESET = 1'b0;

    // Longest prefix wins over a shorter one
    setup_two_routes();
    lookup("two_routes", ip4(10, 1, 2, 3), 0, 1'b1, 5'd7);

    // Equal masks: lower index wins
    clear_table();
    tb_prefix[2] = ip4(192, 168, 1, 0);
    tb_mask[2]   = ip4(255, 255, 255, 0);
    tb_prefix[5] = ip4(192, 168, 1, 0);
    tb_mask[5]   = ip4(255, 255, 255, 0);
    tbl_valid    = 32'h0000_0024;
    lookup("tie", ip4(192, 168, 1, 9), 0, 1'b1, 5'd2);

    // Default route alone, then an empty table (miss)
    clear_table();
    tbl_valid = 32'h0000_0001;
    lookup("default_route", ip4(8, 8, 8, 8), 0, 1'b1, 5'd0);
    tbl_valid = 32'h0;
    lookup("miss", ip4(8, 8, 8, 8), 0, 1'b0, 5'd0);

    // Default route loses to any specific match found later in the scan
    tbl_valid    = 32'h0000_0201;
    tb_prefix[9] = ip4(10, 0, 0, 0);
    tb_mask[9]   = ip4(255, 0, 0, 0);
    lookup("default_vs_specific", ip4(10, 9, 9, 9), 0, 1'b1, 5'd9);

    // Consumer back-pressure
    setup_two_routes();
    lookup("backpressure", ip4(10, 1, 2, 3), 10, 1'b1, 5'd7);

    // Reset in the middle of a scan discards the lookup
    @(negedge clk);
    req_ip    = ip4(10, 1, 2, 3);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("scan.tbl_rd_en", 32'(tbl_rd_en), 32'd1);
    check("scan.tbl_rd_addr", 32'(tbl_rd_addr), 32'd14);
    #2;
    AXI_RESET  = 1'b1;
    miss_model = 32'd0;
    #1;
    check_reset_outputs("mid_scan_reset");
    @(posedge clk);
    #3;
    AXI_RESET = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b0) ok = 1'b0;
    end
    check("mid_scan_reset.no_rsp", 32'(ok), 32'd1);
    lookup("after_reset", ip4(10, 1, 2, 3), 0, 1'b1, 5'd7);

    // Randomized tables against the reference model
    for (int r = 0; r < 30; r++) begin
      ip        = $urandom();
      tbl_valid = (r % 6 == 5) ? 32'h0 : $urandom();
      for (int i = 0; i < NUM; i++) begin
        len          = $urandom_range(0, 32);
        tb_mask[i]   = len_mask(len);
        tb_prefix[i] = ($urandom_range(0, 1) == 1) ? ip : $urandom();
      end
      hold = $urandom_range(0, 3);
      ref_lookup(ip, e_hit, e_idx);
      lookup($sformatf("rand%0d", r), ip, hold, e_hit, e_idx);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
